ex_cond_flag_stage: RTL and testbench

//  Execute-stage back end: consumes ALU result and N/Z/V flags, holds architectural NZV flags register.

---
 rtl/ex_cond_flag_stage.sv | 114 +++++++++++
 tb/tb_ex_cond_flag_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_cond_flag_stage.sv
// rtl/ex_cond_flag_stage.sv - execute back end: ARM condition check, NZV flags, 2-entry skid queue
module ex_cond_flag_stage #(
    parameter int N    = 32,
    parameter int REGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    alu_result,
    input  logic            alu_n,
    input  logic            alu_z,
    input  logic            alu_v,
    input  logic [3:0]      cond,
    input  logic            set_flags,
    input  logic [REGW-1:0] rd,
    input  logic            wr_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [REGW-1:0] out_rd,
    output logic            out_wr_en,
    output logic            out_taken,
    output logic [2:0]      flags_nzv
);

    logic [1:0]      count;
    logic [N-1:0]    res0, res1;
    logic [REGW-1:0] rd0, rd1;
    logic            taken0, taken1;
    logic            wr0, wr1;
    logic [2:0]      flags;
    logic            push, pop, taken_in;

    // Flags are {N,Z,V}; carry-based conditions have no C flag to test and never pass.
    function automatic logic cond_pass(input logic [3:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign in_ready   = (count != 2'd2);
    assign out_valid  = (count != 2'd0);
    assign push       = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready & ~flush;
    assign taken_in   = cond_pass(cond, flags);

    assign out_result = res0;
    assign out_rd     = rd0;
    assign out_taken  = taken0;
    assign out_wr_en  = wr0;
    assign flags_nzv  = flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            flags  <= 3'b000;
            res0   <= '0;
            res1   <= '0;
            rd0    <= '0;
            rd1    <= '0;
            taken0 <= 1'b0;
            taken1 <= 1'b0;
            wr0    <= 1'b0;
            wr1    <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                res0   <= res1;
                rd0    <= rd1;
                taken0 <= taken1;
                wr0    <= wr1;
            end
            // Slot 0 is the head; a push lands there whenever the head is empty after this edge.
            if (push) begin
                if (count == 2'd0 || pop) begin
                    res0   <= alu_result;
                    rd0    <= rd;
                    taken0 <= taken_in;
                    wr0    <= wr_en & taken_in;
                end else begin
                    res1   <= alu_result;
                    rd1    <= rd;
                    taken1 <= taken_in;
                    wr1    <= wr_en & taken_in;
                end
                if (set_flags && taken_in)
                    flags <= {alu_n, alu_z, alu_v};
            end
            if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;
        end
    end

endmodule

// File: tb/tb_ex_cond_flag_stage.sv
// tb/tb_ex_cond_flag_stage.sv - model-checked bench for ex_cond_flag_stage
module tb_ex_cond_flag_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] alu_result;
    logic        alu_n, alu_z, alu_v;
    logic [3:0]  cond;
    logic        set_flags;
    logic [3:0]  rd;
    logic        wr_en;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wr_en, out_taken;
    logic [2:0]  flags_nzv;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        taken;
        logic        wr;
    } ent_t;

    ent_t       mq[$];
    ent_t       log_q[$];
    logic [2:0] mflags;

    always #5 clk = ~clk;

    ex_cond_flag_stage #(.N(32), .REGW(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .cond(cond), .set_flags(set_flags), .rd(rd), .wr_en(wr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wr_en(out_wr_en), .out_taken(out_taken), .flags_nzv(flags_nzv)
    );

    function automatic bit passes(input logic [3:0] c, input logic [2:0] f);
        bit n = f[2], z = f[1], v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1;
            default: return 0;
        endcase
    endfunction

    // Model: queue of entries plus committed flags, updated from the inputs seen at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mflags = 3'b000;
        end else if (flush) begin
            mq.delete();
        end else begin
            int sz;
            sz = mq.size();
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) begin
                ent_t e;
                bit t;
                t = passes(cond, mflags);
                e.res = alu_result;
                e.rd = rd;
                e.taken = t;
                e.wr = wr_en && t;
                mq.push_back(e);
                if (set_flags && t) mflags = {alu_n, alu_z, alu_v};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != 2});
        chk("flags_nzv", {29'd0, flags_nzv}, {29'd0, mflags});
        if (mq.size() != 0) begin
            chk("out_result", out_result, mq[0].res);
            chk("out_rd", {28'd0, out_rd}, {28'd0, mq[0].rd});
            chk("out_taken", {31'd0, out_taken}, {31'd0, mq[0].taken});
            chk("out_wr_en", {31'd0, out_wr_en}, {31'd0, mq[0].wr});
            if (out_ready && !flush && rst_n) log_q.push_back(mq[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] r, input logic [2:0] nzv, input logic [3:0] c,
                         input logic sf, input logic [3:0] d, input logic w);
        in_valid   = 1'b1;
        alu_result = r;
        {alu_n, alu_z, alu_v} = nzv;
        cond       = c;
        set_flags  = sf;
        rd         = d;
        wr_en      = w;
    endtask

    task automatic push_one(input logic [31:0] r, input logic [2:0] nzv, input logic [3:0] c,
                            input logic sf, input logic [3:0] d, input logic w);
        bit acc;
        acc = 0;
        drive(r, nzv, c, sf, d, w);
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {29'd0, flags_nzv}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    int base;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_result = '0; {alu_n, alu_z, alu_v} = 3'b000;
        cond = 4'hE; set_flags = 1'b0; rd = '0; wr_en = 1'b0;
        step();
        do_reset();
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);

        // Reset mid-stream with two entries held
        out_ready = 1'b0;
        push_one(32'hA, 3'b100, 4'hE, 1'b1, 4'd1, 1'b1);
        push_one(32'hB, 3'b000, 4'hE, 1'b0, 4'd2, 1'b1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        do_reset();
        out_ready = 1'b1;

        // AL with zero flags then EQ: fails against Z=0
        base = log_q.size();
        push_one(32'h5, 3'b000, 4'hE, 1'b1, 4'd1, 1'b1);
        push_one(32'h6, 3'b000, 4'h0, 1'b0, 4'd2, 1'b1);
        idle(3);
        chk("t2_first_taken", {31'd0, log_q[base].taken}, 32'd1);
        chk("t2_second_taken", {31'd0, log_q[base+1].taken}, 32'd0);
        chk("t2_second_wr", {31'd0, log_q[base+1].wr}, 32'd0);
        chk("t2_flags", {29'd0, flags_nzv}, 32'd0);

        // Zero result sets Z; back-to-back EQ passes, GT fails
        base = log_q.size();
        push_one(32'h0, 3'b010, 4'hE, 1'b1, 4'd3, 1'b1);
        push_one(32'h7, 3'b000, 4'h0, 1'b0, 4'd4, 1'b1);
        push_one(32'h8, 3'b000, 4'hC, 1'b0, 4'd5, 1'b1);
        idle(3);
        chk("t3_eq_taken", {31'd0, log_q[base+1].taken}, 32'd1);
        chk("t3_eq_wr", {31'd0, log_q[base+1].wr}, 32'd1);
        chk("t3_gt_taken", {31'd0, log_q[base+2].taken}, 32'd0);
        chk("t3_flags", {29'd0, flags_nzv}, 32'b010);

        // All sixteen conditions under two flag settings
        for (int s = 0; s < 2; s++) begin
            base = log_q.size();
            push_one(32'h1, (s == 0) ? 3'b101 : 3'b010, 4'hE, 1'b1, 4'd0, 1'b0);
            for (int c = 0; c < 16; c++)
                push_one(32'd100 + c, 3'b111, c[3:0], 1'b0, c[3:0], 1'b1);
            idle(3);
            if (s == 0) begin
                chk("sw_ge_taken", {31'd0, log_q[base+1+10].taken}, 32'd1);
                chk("sw_lt_taken", {31'd0, log_q[base+1+11].taken}, 32'd0);
                chk("sw_gt_taken", {31'd0, log_q[base+1+12].taken}, 32'd1);
                chk("sw_cs_taken", {31'd0, log_q[base+1+2].taken}, 32'd0);
            end else begin
                chk("sw_le_taken", {31'd0, log_q[base+1+13].taken}, 32'd1);
                chk("sw_nv_taken", {31'd0, log_q[base+1+15].taken}, 32'd0);
            end
        end

        // Backpressure: third push held by source until downstream drains
        base = log_q.size();
        out_ready = 1'b0;
        push_one(32'd1, 3'b000, 4'hE, 1'b0, 4'd1, 1'b1);
        push_one(32'd2, 3'b000, 4'hE, 1'b0, 4'd2, 1'b1);
        chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
        drive(32'd3, 3'b000, 4'hE, 1'b0, 4'd3, 1'b1);
        step();
        out_ready = 1'b1;
        push_one(32'd3, 3'b000, 4'hE, 1'b0, 4'd3, 1'b1);
        idle(4);
        chk("t4_count", log_q.size() - base, 32'd3);
        chk("t4_pop1", log_q[base].res, 32'd1);
        chk("t4_pop2", log_q[base+1].res, 32'd2);
        chk("t4_pop3", log_q[base+2].res, 32'd3);

        // Simultaneous push and pop with one entry
        out_ready = 1'b0;
        push_one(32'h50, 3'b000, 4'hE, 1'b0, 4'd6, 1'b1);
        out_ready = 1'b1;
        drive(32'h60, 3'b000, 4'hE, 1'b0, 4'd7, 1'b1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t5_head", out_result, 32'h60);
        chk("t5_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle(2);

        // Flush with a full queue and a flag-setting input
        out_ready = 1'b0;
        push_one(32'h70, 3'b000, 4'hE, 1'b0, 4'd8, 1'b1);
        push_one(32'h71, 3'b000, 4'hE, 1'b0, 4'd9, 1'b1);
        drive(32'h72, 3'b110, 4'hE, 1'b1, 4'd10, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_flags", {29'd0, flags_nzv}, 32'b010);
        out_ready = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
